// File: rtl/calc_pkg.sv
// Calculator-wide types shared by the keypad scanner and the controller.
package calc_pkg;

   // Button codes delivered to the controller. B_NONE marks an unmapped position
   // and is also the idle value after reset.
   typedef enum logic [4:0] {
      B_NONE,
      B_NUM_0, B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4,
      B_NUM_5, B_NUM_6, B_NUM_7, B_NUM_8, B_NUM_9,
      B_DOT, B_EQ, B_PLUS, B_MINUS, B_MUL, B_DIV, B_ON
   } active_button_t;

   // Physical matrix position to button. Rows run top to bottom, columns 0-4.
   function automatic active_button_t keypos2button(input logic [2:0] row,
                                                    input logic [2:0] col);
      active_button_t btn;
      btn = B_NONE;
      case (row)
         3'd0: case (col)
            3'd0: btn = B_NUM_7;
            3'd1: btn = B_NUM_8;
            3'd2: btn = B_NUM_9;
            3'd3: btn = B_DIV;
            3'd4: btn = B_ON;
            default: btn = B_NONE;
         endcase
         3'd1: case (col)
            3'd0: btn = B_NUM_4;
            3'd1: btn = B_NUM_5;
            3'd2: btn = B_NUM_6;
            3'd3: btn = B_MUL;
            default: btn = B_NONE;
         endcase
         3'd2: case (col)
            3'd0: btn = B_NUM_1;
            3'd1: btn = B_NUM_2;
            3'd2: btn = B_NUM_3;
            3'd3: btn = B_MINUS;
            default: btn = B_NONE;
         endcase
         3'd3: case (col)
            3'd0: btn = B_NUM_0;
            3'd1: btn = B_DOT;
            3'd2: btn = B_EQ;
            3'd3: btn = B_PLUS;
            default: btn = B_NONE;
         endcase
         default: btn = B_NONE;
      endcase
      return btn;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous levels.
module sync_2ff #(
   parameter int              Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   logic [Width-1:0] meta_reg;
   logic [Width-1:0] sync_reg;

   // First flop may go metastable; the second gives it a full cycle to resolve.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_reg <= ResetValue;
         sync_reg <= ResetValue;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// Row/column keypad scanner: drives one row low at a time, debounces the
// columns and emits a single pulse per accepted press.
module keypad_scanner
   import calc_pkg::*;
#(
   parameter int NumRows        = 4,
   parameter int NumCols        = 5,
   parameter int SettleCycles   = 16,
   parameter int DebounceCycles = 50000
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   output logic [NumRows-1:0] row_o,
   input  logic [NumCols-1:0] col_i,
   output active_button_t     active_button_o,
   output logic               new_input_o
);

   localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
   localparam int COL_W = (NumCols > 1) ? $clog2(NumCols) : 1;
   localparam int SET_W = $clog2(SettleCycles + 1);
   localparam int DEB_W = $clog2(DebounceCycles + 1);

   localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(NumRows - 1);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SettleCycles);
   // The final sample is taken with the counter one short of the target.
   localparam logic [DEB_W-1:0] DEB_FINAL   = DEB_W'(DebounceCycles - 1);

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_HELD
   } state_t;

   state_t             state_reg, state_next;
   logic [ROW_W-1:0]   row_reg, row_next;
   logic [COL_W-1:0]   col_reg, col_next;
   logic [SET_W-1:0]   settle_cnt_reg, settle_cnt_next;
   logic [DEB_W-1:0]   deb_cnt_reg, deb_cnt_next;
   active_button_t     button_reg, button_next;
   logic               new_input_reg, new_input_next;

   logic [NumCols-1:0] col_s;
   logic               any_low;
   logic [COL_W-1:0]   low_idx;
   logic [ROW_W-1:0]   row_inc;
   active_button_t     lookup_btn;

   sync_2ff #(
      .Width      (NumCols),
      .ResetValue ({NumCols{1'b1}})
   ) u_col_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d      (col_i),
      .q      (col_s)
   );

   // Lowest-numbered low column wins when several keys share a row.
   always_comb begin
      any_low = 1'b0;
      low_idx = '0;
      for (int i = NumCols - 1; i >= 0; i--) begin
         if (!col_s[i]) begin
            any_low = 1'b1;
            low_idx = COL_W'(i);
         end
      end
   end

   assign row_inc    = (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
   assign lookup_btn = keypos2button(3'(row_reg), 3'(col_reg));

   // Next-state logic for scan, debounce and hold-until-release.
   always_comb begin
      state_next      = state_reg;
      row_next        = row_reg;
      col_next        = col_reg;
      settle_cnt_next = settle_cnt_reg;
      deb_cnt_next    = deb_cnt_reg;
      button_next     = button_reg;
      new_input_next  = 1'b0;
      case (state_reg)
         S_SCAN: begin
            if (settle_cnt_reg == SETTLE_LAST) begin
               settle_cnt_next = '0;
               if (any_low) begin
                  col_next     = low_idx;
                  deb_cnt_next = DEB_W'(1);
                  state_next   = S_DEBOUNCE;
               end else begin
                  row_next = row_inc;
               end
            end else begin
               settle_cnt_next = settle_cnt_reg + SET_W'(1);
            end
         end
         S_DEBOUNCE: begin
            if (any_low && (low_idx == col_reg)) begin
               if (deb_cnt_reg == DEB_FINAL) begin
                  // Press accepted; the counter is reused to time the release.
                  deb_cnt_next = '0;
                  state_next   = S_HELD;
                  if (lookup_btn != B_NONE) begin
                     button_next    = lookup_btn;
                     new_input_next = 1'b1;
                  end
               end else begin
                  deb_cnt_next = deb_cnt_reg + DEB_W'(1);
               end
            end else begin
               deb_cnt_next    = '0;
               settle_cnt_next = '0;
               row_next        = row_inc;
               state_next      = S_SCAN;
            end
         end
         S_HELD: begin
            if (any_low) begin
               deb_cnt_next = '0;
            end else if (deb_cnt_reg == DEB_FINAL) begin
               deb_cnt_next    = '0;
               settle_cnt_next = '0;
               row_next        = '0;
               state_next      = S_SCAN;
            end else begin
               deb_cnt_next = deb_cnt_reg + DEB_W'(1);
            end
         end
         default: begin
            state_next = S_SCAN;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= S_SCAN;
         row_reg        <= '0;
         col_reg        <= '0;
         settle_cnt_reg <= '0;
         deb_cnt_reg    <= '0;
         button_reg     <= B_NONE;
         new_input_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         row_reg        <= row_next;
         col_reg        <= col_next;
         settle_cnt_reg <= settle_cnt_next;
         deb_cnt_reg    <= deb_cnt_next;
         button_reg     <= button_next;
         new_input_reg  <= new_input_next;
      end
   end

   // One-hot-low row drive decoded from the registered row index.
   generate
      for (genvar gi = 0; gi < NumRows; gi++) begin : g_row_drive
         assign row_o[gi] = (row_reg != ROW_W'(gi));
      end
   endgenerate

   assign active_button_o = button_reg;
   assign new_input_o     = new_input_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a modelled 4x5 key matrix.
module tb_keypad_scanner;
   import calc_pkg::*;

   logic           clk;
   logic           rst_n;
   logic [3:0]     row_o;
   logic [4:0]     col_i;
   active_button_t active_button_o;
   logic           new_input_o;

   logic keys [4][5];

   int checks;
   int passes;
   int pulse_cnt;
   logic prev_pulse;

   typedef struct {
      int             r;
      int             c;
      active_button_t exp_btn;
      int             exp_pulses;
   } vec_t;

   vec_t vecs [10];

   keypad_scanner #(
      .NumRows        (4),
      .NumCols        (5),
      .SettleCycles   (2),
      .DebounceCycles (4)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .row_o           (row_o),
      .col_i           (col_i),
      .active_button_o (active_button_o),
      .new_input_o     (new_input_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Matrix model: a held key pulls its column low while its row is driven low.
   always_comb begin
      col_i = 5'b11111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 5; c++)
            if (keys[r][c] && !row_o[r]) col_i[c] = 1'b0;
   end

   // Pulse counter; also flags back-to-back pulses.
   always @(posedge clk) begin
      if (new_input_o) begin
         pulse_cnt++;
         if (prev_pulse) begin
            checks++;
            $display("FAIL back_to_back_pulse: new_input_o high on two consecutive cycles, required single-cycle");
         end
      end
      prev_pulse = new_input_o;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_keys();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 5; c++)
            keys[r][c] = 1'b0;
   endtask

   function automatic logic [3:0] row_pat(input int r);
      logic [3:0] one;
      one = 4'b0001;
      return 4'b1111 ^ (one << r);
   endfunction

   initial begin
      int pc0;
      int n;
      int first;
      logic [3:0] held;

      checks = 0;
      passes = 0;
      pulse_cnt = 0;
      prev_pulse = 1'b0;
      clear_keys();
      rst_n = 1'b0;

      vecs[0] = '{1, 1, B_NUM_5, 1};
      vecs[1] = '{0, 4, B_ON,    1};
      vecs[2] = '{2, 3, B_MINUS, 1};
      vecs[3] = '{3, 3, B_PLUS,  1};
      vecs[4] = '{0, 3, B_DIV,   1};
      vecs[5] = '{1, 3, B_MUL,   1};
      vecs[6] = '{3, 1, B_DOT,   1};
      vecs[7] = '{2, 4, B_DOT,   0};
      vecs[8] = '{3, 0, B_NUM_0, 1};
      vecs[9] = '{2, 0, B_NUM_1, 1};

      // Reset state
      run(3);
      check("reset_row", 32'(row_o), 32'(4'b1110));
      check("reset_btn", 32'(active_button_o), 32'(B_NONE));
      check("reset_pulse", 32'(new_input_o), 32'd0);

      // Idle scan: each row held for three cycles
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         check($sformatf("scan_row_k%0d", k), 32'(row_o), 32'(row_pat((k / 3) % 4)));
         @(negedge clk);
      end
      check("idle_no_pulse", 32'(pulse_cnt), 32'd0);
      check("idle_btn", 32'(active_button_o), 32'(B_NONE));

      // Single keys from the table
      for (int i = 0; i < 10; i++) begin
         pc0 = pulse_cnt;
         keys[vecs[i].r][vecs[i].c] = 1'b1;
         run(40);
         held = row_pat(vecs[i].r);
         check($sformatf("v%0d_held_row", i), 32'(row_o), 32'(held));
         clear_keys();
         if (vecs[i].r != 0) begin
            n = 0;
            while (row_o == held && n < 30) begin
               @(negedge clk);
               n++;
            end
            check($sformatf("v%0d_release_cycles", i), 32'(n), 32'd6);
            check($sformatf("v%0d_resume_row", i), 32'(row_o), 32'(4'b1110));
         end
         run(20);
         check($sformatf("v%0d_pulses", i), 32'(pulse_cnt - pc0), 32'(vecs[i].exp_pulses));
         check($sformatf("v%0d_btn", i), 32'(active_button_o), 32'(vecs[i].exp_btn));
      end

      // Bouncing contact on (3,2)
      pc0 = pulse_cnt;
      keys[3][2] = 1'b1;
      run(2);
      keys[3][2] = 1'b0;
      run(1);
      keys[3][2] = 1'b1;
      run(40);
      check("bounce_held_row", 32'(row_o), 32'(4'b0111));
      clear_keys();
      run(30);
      check("bounce_pulses", 32'(pulse_cnt - pc0), 32'd1);
      check("bounce_btn", 32'(active_button_o), 32'(B_EQ));

      // Two keys in row 0; lowest column wins, partial release is ignored
      pc0 = pulse_cnt;
      keys[0][1] = 1'b1;
      keys[0][3] = 1'b1;
      run(40);
      check("multi_pulses", 32'(pulse_cnt - pc0), 32'd1);
      check("multi_btn", 32'(active_button_o), 32'(B_NUM_8));
      keys[0][1] = 1'b0;
      run(30);
      check("multi_partial_row", 32'(row_o), 32'(4'b1110));
      check("multi_partial_pulses", 32'(pulse_cnt - pc0), 32'd1);
      clear_keys();
      run(30);
      check("multi_release_pulses", 32'(pulse_cnt - pc0), 32'd1);
      check("multi_release_btn", 32'(active_button_o), 32'(B_NUM_8));

      // Reset asserted mid-debounce with (0,4) held
      keys[0][4] = 1'b1;
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      run(4);
      pc0 = pulse_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_row", 32'(row_o), 32'(4'b1110));
      check("midrst_btn", 32'(active_button_o), 32'(B_NONE));
      check("midrst_pulse", 32'(new_input_o), 32'd0);
      run(3);
      check("midrst_no_pulse", 32'(pulse_cnt - pc0), 32'd0);

      // Rescan after reset release, key still held
      rst_n = 1'b1;
      first = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (new_input_o && first < 0) first = k;
      end
      check("rescan_latency", 32'(first), 32'd6);
      check("rescan_pulses", 32'(pulse_cnt - pc0), 32'd1);
      check("rescan_btn", 32'(active_button_o), 32'(B_ON));
      clear_keys();
      run(30);
      check("rescan_release_pulses", 32'(pulse_cnt - pc0), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
